// File: rtl/sound_mixer_pkg.sv
// Shared sizes and types for the sound mixer datapath stages.
package sound_mixer_pkg;

    localparam int unsigned SAMPLE_W   = 24;
    localparam int unsigned SLOT_BITS  = 32;
    localparam int unsigned FRAME_BITS = 64;
    localparam int unsigned FIFO_DEPTH = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } tx_state_t;

endpackage

// File: rtl/i2s_transmitter_if.sv
// Sample stream in, I2S serial lines out.
interface i2s_transmitter_if;
    import sound_mixer_pkg::*;

    logic [SAMPLE_W-1:0] in_data;
    logic                in_valid;
    logic                in_ready;
    logic                sclk;
    logic                lrclk;
    logic                sdata;
    logic                underrun;

    modport master (
        output in_data, in_valid,
        input  in_ready, sclk, lrclk, sdata, underrun
    );

    modport slave (
        input  in_data, in_valid,
        output in_ready, sclk, lrclk, sdata, underrun
    );
endinterface

// File: rtl/sample_fifo.sv
// Small first-word-fall-through sample FIFO with occupancy count.
module sample_fifo #(
    parameter  int unsigned WIDTH = 24,
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic [CNT_W-1:0] count
);
    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & ((count < CNT_W'(DEPTH)) | do_pop);
    assign head    = mem[rd_ptr];

    // Simultaneous push and pop leaves the count unchanged.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end
endmodule

// File: rtl/i2s_transmitter.sv
// I2S transmitter: buffers PCM samples and serialises them as 2x32-bit slots, MSB first.
module i2s_transmitter
    import sound_mixer_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    i2s_transmitter_if.slave bus
);
    localparam int unsigned DIV_W = 8;
    localparam int unsigned BIT_W = $clog2(FRAME_BITS);
    localparam int unsigned POS_W = $clog2(SLOT_BITS);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

    localparam logic [1:0] S_IDLE  = 2'(IDLE);
    localparam logic [1:0] S_RUN   = 2'(RUN);
    localparam logic [1:0] S_DRAIN = 2'(DRAIN);

    logic [1:0]          state,      state_nxt;
    logic [DIV_W-1:0]    div_cnt,    div_nxt;
    logic [BIT_W-1:0]    bit_cnt,    bit_nxt;
    logic [SAMPLE_W-1:0] shreg,      shreg_nxt;
    logic                sclk_q,     sclk_nxt;
    logic                lrclk_q,    lrclk_nxt;
    logic                sdata_q,    sdata_nxt;
    logic                underrun_q, underrun_nxt;

    logic [BIT_W-1:0]    bit_inc;
    logic [POS_W-1:0]    pos_inc;
    logic                fifo_pop;
    logic                fifo_push;
    logic                fifo_empty;
    logic [SAMPLE_W-1:0] fifo_head;
    logic [CNT_W-1:0]    fifo_count;
    logic                in_ready_c;

    sample_fifo #(
        .WIDTH (SAMPLE_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (bus.in_data),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign in_ready_c   = ~reset & (fifo_count < CNT_W'(FIFO_DEPTH));
    assign fifo_push    = bus.in_valid & in_ready_c;
    assign bit_inc      = bit_cnt + 1'b1;
    assign pos_inc      = bit_inc[POS_W-1:0];

    assign bus.in_ready = in_ready_c;
    assign bus.sclk     = sclk_q;
    assign bus.lrclk    = lrclk_q;
    assign bus.sdata    = sdata_q;
    assign bus.underrun = underrun_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            div_cnt    <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            sclk_q     <= 1'b0;
            lrclk_q    <= 1'b0;
            sdata_q    <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state      <= state_nxt;
            div_cnt    <= div_nxt;
            bit_cnt    <= bit_nxt;
            shreg      <= shreg_nxt;
            sclk_q     <= sclk_nxt;
            lrclk_q    <= lrclk_nxt;
            sdata_q    <= sdata_nxt;
            underrun_q <= underrun_nxt;
        end
    end

    // Entering RUN acts as the bit-0 falling edge of the first left slot.
    always_comb begin
        state_nxt    = state;
        div_nxt      = div_cnt;
        bit_nxt      = bit_cnt;
        shreg_nxt    = shreg;
        sclk_nxt     = sclk_q;
        lrclk_nxt    = lrclk_q;
        sdata_nxt    = sdata_q;
        underrun_nxt = 1'b0;
        fifo_pop     = 1'b0;

        case (state)
            S_IDLE: begin
                div_nxt   = '0;
                bit_nxt   = '0;
                sclk_nxt  = 1'b0;
                lrclk_nxt = 1'b0;
                sdata_nxt = 1'b0;
                if (enable && !fifo_empty) begin
                    state_nxt = S_RUN;
                    fifo_pop  = 1'b1;
                    shreg_nxt = fifo_head;
                end
            end
            default: begin
                state_nxt = enable ? S_RUN : S_DRAIN;
                if (div_cnt == DIV_W'(CLK_DIV - 1)) begin
                    div_nxt  = '0;
                    sclk_nxt = ~sclk_q;
                    if (sclk_q) begin
                        if (state == S_DRAIN && !enable && bit_cnt == BIT_W'(FRAME_BITS - 1)) begin
                            state_nxt = S_IDLE;
                            bit_nxt   = '0;
                            lrclk_nxt = 1'b0;
                            sdata_nxt = 1'b0;
                            shreg_nxt = '0;
                        end else begin
                            bit_nxt   = bit_inc;
                            lrclk_nxt = bit_inc[BIT_W-1];
                            sdata_nxt = 1'b0;
                            if (pos_inc == '0) begin
                                if (fifo_empty) begin
                                    shreg_nxt    = '0;
                                    underrun_nxt = 1'b1;
                                end else begin
                                    fifo_pop  = 1'b1;
                                    shreg_nxt = fifo_head;
                                end
                            end else if (pos_inc <= POS_W'(SAMPLE_W)) begin
                                sdata_nxt = shreg[SAMPLE_W-1];
                                shreg_nxt = {shreg[SAMPLE_W-2:0], 1'b0};
                            end
                        end
                    end
                end else begin
                    div_nxt = div_cnt + 1'b1;
                end
            end
        endcase
    end
endmodule

// File: tb/tb_i2s_transmitter.sv
// Directed bench for i2s_transmitter with CLK_DIV=4 (8 clk per bit, 256 clk per slot).
module tb_i2s_transmitter;
    logic clk;
    logic reset;
    logic enable;
    int   n_run  = 0;
    int   n_fail = 0;
    int   cur    = 0;
    int   ur_seen = 0;
    int   ur_base;

    i2s_transmitter_if bus ();

    i2s_transmitter #(.CLK_DIV(4)) dut (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) if (bus.underrun === 1'b1) ur_seen <= ur_seen + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: run did not finish, observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // cur counts negedges since the negedge on which enable was raised.
    task automatic goto_idx(input int idx);
        while (cur < idx) begin
            @(negedge clk);
            cur++;
        end
    endtask

    task automatic push(input logic [23:0] d);
        bus.in_data  = d;
        bus.in_valid = 1'b1;
        @(negedge clk);
        cur++;
        bus.in_valid = 1'b0;
    endtask

    task automatic read_slot(input int j, output logic [23:0] s, output logic tail_ok, output logic lr_ok);
        s = '0;
        tail_ok = 1'b1;
        lr_ok = 1'b1;
        for (int p = 0; p < 32; p++) begin
            goto_idx(8 * (32 * j + p) + 5);
            if (p >= 1 && p <= 24) s[24 - p] = bus.sdata;
            else if (bus.sdata !== 1'b0) tail_ok = 1'b0;
            if (bus.lrclk !== 1'(j % 2)) lr_ok = 1'b0;
        end
    endtask

    logic [23:0] d [7];
    logic [23:0] sq [16];
    logic [23:0] s;
    logic        t_ok;
    logic        l_ok;

    initial begin
        d[0] = 24'h111111; d[1] = 24'hABCDEF; d[2] = 24'h222222; d[3] = 24'h35A5C3;
        d[4] = 24'h444444; d[5] = 24'h555555; d[6] = 24'h666666;
        for (int i = 0; i < 16; i++) sq[i] = 24'((i + 1) * 32'h00B35A17);

        reset = 1'b1;
        enable = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data = '0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_sclk", bus.sclk, 0);
        check("rst_lrclk", bus.lrclk, 0);
        check("rst_sdata", bus.sdata, 0);
        check("rst_underrun", bus.underrun, 0);
        check("rst_in_ready", bus.in_ready, 0);
        reset = 1'b0;
        #1;
        check("post_rst_in_ready", bus.in_ready, 1);
        @(negedge clk);

        // Left 800001, right 7FFFFF, then an underrun slot
        push(24'h800001);
        push(24'h7FFFFF);
        check("a_count", dut.u_fifo.count, 2);
        enable = 1'b1;
        cur = 0;
        read_slot(0, s, t_ok, l_ok);
        check("a_left_data", s, 24'h800001);
        check("a_left_tail", t_ok, 1);
        check("a_left_lr", l_ok, 1);
        goto_idx(256);
        check("a_lr_last_low", bus.lrclk, 0);
        goto_idx(257);
        check("a_lr_rise", bus.lrclk, 1);
        check("a_no_ur_right", bus.underrun, 0);
        read_slot(1, s, t_ok, l_ok);
        check("a_right_data", s, 24'h7FFFFF);
        check("a_right_tail", t_ok, 1);
        check("a_right_lr", l_ok, 1);
        goto_idx(512);
        check("a_ur_before", bus.underrun, 0);
        goto_idx(513);
        check("a_ur_pulse", bus.underrun, 1);
        check("a_ur_sdata", bus.sdata, 0);
        goto_idx(514);
        check("a_ur_end", bus.underrun, 0);
        enable = 1'b0;
        goto_idx(1030);
        check("a_idle_sclk", bus.sclk, 0);
        check("a_idle_lrclk", bus.lrclk, 0);

        // Fill to four, hold the fifth until the first pop frees a slot
        push(d[0]);
        push(d[1]);
        push(d[2]);
        check("b_ready_3", bus.in_ready, 1);
        push(d[3]);
        check("b_ready_full", bus.in_ready, 0);
        check("b_count_full", dut.u_fifo.count, 4);
        bus.in_data = d[4];
        bus.in_valid = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("b_fifth_held", bus.in_ready, 0);
        check("b_count_held", dut.u_fifo.count, 4);
        enable = 1'b1;
        cur = 0;
        goto_idx(1);
        check("b_ready_after_pop", bus.in_ready, 1);
        check("b_count_after_pop", dut.u_fifo.count, 3);
        goto_idx(2);
        check("b_fifth_taken", bus.in_ready, 0);
        check("b_count_refill", dut.u_fifo.count, 4);
        bus.in_valid = 1'b0;

        // Drop enable at bit 10: frame finishes, next entries stay queued
        goto_idx(83);
        enable = 1'b0;
        read_slot(1, s, t_ok, l_ok);
        check("c_right_data", s, d[1]);
        check("c_right_lr", l_ok, 1);
        goto_idx(513);
        check("c_idle_sclk", bus.sclk, 0);
        check("c_idle_lrclk", bus.lrclk, 0);
        check("c_idle_sdata", bus.sdata, 0);
        check("c_idle_ur", bus.underrun, 0);
        check("c_count_kept", dut.u_fifo.count, 3);
        goto_idx(520);
        check("c_still_idle", bus.sclk, 0);

        // Reset mid-frame at bit 40 with three queued
        enable = 1'b1;
        cur = 0;
        goto_idx(1);
        push(d[5]);
        check("d_count_a", dut.u_fifo.count, 3);
        goto_idx(300);
        push(d[6]);
        goto_idx(325);
        check("d_pre_sclk", bus.sclk, 1);
        check("d_pre_lrclk", bus.lrclk, 1);
        check("d_pre_sdata", bus.sdata, 32'(d[3][16]));
        check("d_pre_count", dut.u_fifo.count, 3);
        reset = 1'b1;
        #1;
        check("d_rst_sclk", bus.sclk, 0);
        check("d_rst_lrclk", bus.lrclk, 0);
        check("d_rst_sdata", bus.sdata, 0);
        check("d_rst_ur", bus.underrun, 0);
        check("d_rst_ready", bus.in_ready, 0);
        check("d_rst_count", dut.u_fifo.count, 0);
        enable = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("d_rel_ready", bus.in_ready, 1);
        check("d_rel_count", dut.u_fifo.count, 0);
        @(negedge clk);

        // One sample per slot for 8 frames: order L,R preserved, no underrun
        push(sq[0]);
        enable = 1'b1;
        cur = 0;
        ur_base = ur_seen;
        for (int j = 0; j < 16; j++) begin
            if (j < 15) begin
                goto_idx(256 * j + 2);
                push(sq[j + 1]);
            end
            read_slot(j, s, t_ok, l_ok);
            check($sformatf("e_slot%0d_data", j), s, sq[j]);
            check($sformatf("e_slot%0d_tail", j), t_ok, 1);
            check($sformatf("e_slot%0d_lr", j), l_ok, 1);
        end
        goto_idx(4096);
        check("e_no_underrun", ur_seen - ur_base, 0);
        goto_idx(4098);
        check("e_underrun_after_stream", ur_seen - ur_base, 1);
        enable = 1'b0;
        goto_idx(4096 + 520);
        check("e_idle_sclk", bus.sclk, 0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule

// File: doc/i2s_transmitter.md
I2S_TRANSMITTER -- requirements
Module: i2s_transmitter

Interface
REQ-001 Parameter CLK_DIV, default 4: clk cycles per sclk half-period; legal range 2..255.
REQ-002 clk  input  1  system clock; all state on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 enable  input  1  1 = transmit frames; 0 = finish current frame, then idle.
REQ-005 in_data  input  24  signed PCM sample from the upstream stream.
REQ-006 in_valid  input  1  in_data is valid this cycle.
REQ-007 in_ready  output  1  block can accept a sample this cycle.
REQ-008 sclk  output  1  I2S bit clock.
REQ-009 lrclk  output  1  word select; 0 = left slot, 1 = right slot.
REQ-010 sdata  output  1  serial data, MSB first.
REQ-011 underrun  output  1  one-clk pulse when a slot starts with the buffer empty.

Function
REQ-012 A sample SHALL be accepted exactly on a cycle with in_valid=1 and in_ready=1, and written into a 4-entry FIFO.
REQ-013 in_ready SHALL be 0 while reset is asserted and SHALL equal (FIFO count < 4) otherwise.
REQ-014 On a simultaneous push and pop, the FIFO count SHALL be unchanged and data order SHALL be preserved.
REQ-015 States: IDLE, RUN, DRAIN.
REQ-016 In IDLE, sclk, lrclk and sdata SHALL be held at 0.
REQ-017 IDLE->RUN SHALL occur when enable=1 and the FIFO is non-empty.
REQ-018 On entering RUN, bit_cnt=0, div_cnt=0, and the FIFO head SHALL be popped as the left sample.
REQ-019 RUN->DRAIN SHALL occur when enable=0.
REQ-020 DRAIN->RUN SHALL occur if enable returns to 1 before the frame ends.
REQ-021 DRAIN->IDLE SHALL occur on the sclk falling edge that would move bit_cnt from 63 to 0; no pop occurs on that edge.
REQ-022 div_cnt SHALL count 0..CLK_DIV-1; at CLK_DIV-1 it wraps and sclk toggles, giving an sclk period of 2*CLK_DIV clk.
REQ-023 On each sclk falling edge, bit_cnt (6 bits) SHALL increment modulo 64, and lrclk, sdata and any pop SHALL update in the same clk cycle.
REQ-024 lrclk SHALL equal bit_cnt[5].
REQ-025 With slot position p = bit_cnt[4:0], sdata SHALL be: p=0 -> 0; p=1..24 -> sample bit (24-p); p=25..31 -> 0 (I2S one-bit delay).
REQ-026 At p=0 of every slot in RUN or DRAIN, the FIFO head SHALL be popped into the shift register.
REQ-027 If the FIFO is empty at p=0, the slot SHALL transmit all zeros and underrun SHALL pulse for exactly that one clk cycle.
REQ-028 Left/right alternation SHALL follow acceptance order: samples 0, 2, 4... go to left slots and samples 1, 3, 5... go to right slots.
REQ-029 Transmit latency: MSB on sdata 1 sclk period after the slot's lrclk edge.

Reset
REQ-030 Reset SHALL force state=IDLE, FIFO empty, div_cnt=0, bit_cnt=0, shift register=0, sclk=0, lrclk=0, sdata=0, underrun=0, in_ready=0.
REQ-031 Reset asserted mid-frame SHALL discard all buffered and in-flight samples immediately, with no completion of the frame.

Structure
REQ-032 Package sound_mixer_pkg SHALL hold SAMPLE_W=24, SLOT_BITS=32, FRAME_BITS=64, FIFO_DEPTH=4 and the tx_state_t enum {IDLE, RUN, DRAIN}.
REQ-033 The FIFO SHALL be the sub-module sample_fifo (24-bit, depth 4, count output), reusable by other mixer stages.

Verification
REQ-034 Bench: CLK_DIV=4, push 24'h800001 then 24'h7FFFFF, enable=1 -> lrclk low for 256 clk; sdata bits 1..24 = 1000...0001; right slot = 0111...1111; underrun pulses at the next left slot.
REQ-035 Bench: push 5 samples back-to-back while IDLE with enable=0 -> in_ready falls after the 4th push and the 5th is held; enable=1 -> in_ready returns 1 one clk after the first pop.
REQ-036 Bench: enable=0 at bit_cnt=10 -> frame completes through bit 63; state=IDLE; sclk=lrclk=sdata=0; the next FIFO entry is still present.
REQ-037 Bench: assert reset at bit_cnt=40 with 3 samples queued -> all outputs 0 in the same cycle; after release, in_ready=1 and FIFO count=0.
REQ-038 Bench: push one sample per 256 clk continuously -> no underrun over 8 frames; the sample sequence on sdata matches the input order L,R,L,R.
